sync_down_counter: RTL and testbench
====================================

SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter and load-value width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: load  input  1  when high, load_val SHALL be captured as the new count and reload value.
REQ-005 Port: load_val  input  WIDTH  start/reload value (unsigned).
REQ-006 Port: en  input  1  count enable; one decrement step per clk edge while high.
REQ-007 Port: auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled on the terminal step.
REQ-008 Port: q  output  WIDTH  current count, registered.
REQ-009 Port: tc  output  1  terminal-count pulse, registered, one clk cycle wide.
REQ-010 Port: busy  output  1  high while state is RUN.
REQ-011 Port: done  output  1  high while state is DONE.

Function
REQ-012 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE; busy and done SHALL decode directly from state.
REQ-013 Priority on each edge SHALL be reset > load > en; en SHALL be ignored on a load cycle.
REQ-014 load with load_val != 0, in any state: q <= load_val, reload register <= load_val, tc <= 0, state <= RUN.
REQ-015 load with load_val == 0, in any state: q <= 0, reload register <= 0, tc <= 0, state <= IDLE.
REQ-016 RUN, en=1, q > 1: q <= q - 1, tc <= 0, state stays RUN.
REQ-017 RUN, en=1, q == 1: q <= 0, tc <= 1 (asserted in the same cycle q first reads 0).
REQ-018 On the REQ-017 step with auto_reload=1, state SHALL stay RUN; with auto_reload=0, state SHALL go to DONE.
REQ-019 RUN, en=1, q == 0 (periodic mode only): q <= reload register, tc <= 0; the period is therefore reload+1 enabled cycles.
REQ-020 RUN, en=0: q, state and reload register SHALL hold; tc <= 0.
REQ-021 IDLE or DONE without load: q SHALL hold its value; en and auto_reload are ignored; tc <= 0.
REQ-022 q SHALL never wrap below 0; no decrement from 0 SHALL occur in any state.
REQ-023 tc SHALL be high for exactly one cycle per terminal step, even if en stays high.
REQ-024 Arithmetic SHALL be unsigned WIDTH-bit; the reload register SHALL be WIDTH bits.

Reset
REQ-025 On reset, the following SHALL take effect at the next rising clk edge: q = 0, reload register = 0, tc = 0, state = IDLE (busy = 0, done = 0).
REQ-026 Reset asserted mid-count SHALL abort the count with no tc pulse, regardless of load or en in the same cycle.
REQ-027 The block SHALL have no asynchronous reset path; all outputs SHALL be glitch-free registers or state decodes.

Verification
REQ-028 One-shot: reset; load=1, load_val=3; then en=1, auto_reload=0 -> q = 3,2,1,0; tc=1 only on the cycle q becomes 0; done=1 and busy=0 from then on; q holds 0.
REQ-029 Periodic: load_val=2, auto_reload=1, en held high for 9 cycles -> q = 2,1,0,2,1,0,2,1,0 after load; tc pulses on every third cycle; busy stays 1.
REQ-030 Enable gating: load_val=5; en toggles 1,0,0,1 -> q = 4,4,4,3; tc stays 0.
REQ-031 Simultaneous events: RUN with q=1, load=1, load_val=7, en=1 -> q=7, tc=0, state RUN; the next cycle with reset=1 and load=1 -> q=0, IDLE.
REQ-032 Zero load: load_val=0 -> q=0, IDLE, busy=0, done=0; 4 cycles with en=1 -> q stays 0, no tc.
REQ-033 Max value: WIDTH=4, load_val=15, one-shot -> exactly 15 enabled cycles to q=0, single tc, no wrap to 15.

Source files
------------

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot / periodic modes and a one-cycle
// terminal-count pulse. Synchronous active-high reset; all state on clk rise.
module sync_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State register; busy/done are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state: load wins over en; a count of 0 in RUN only occurs in periodic mode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (en) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              count_d = ZERO;
              tc_d    = 1'b1;
              state_d = auto_reload ? ST_RUN : ST_DONE;
            end else begin
              count_d = reload_q;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter (WIDTH=4): one task per scenario,
// each comparing {q, tc, busy, done} against hand-computed values.
module tb_sync_down_counter;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if ({q, tc, busy, done} !== exp) begin
      errors++;
      $display("FAIL reset: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
               q, tc, busy, done);
    end
  endtask

  task automatic test_one_shot();
    logic [6:0] exp [5];
    exp[0] = {4'd3, 1'b0, 1'b1, 1'b0};
    exp[1] = {4'd2, 1'b0, 1'b1, 1'b0};
    exp[2] = {4'd1, 1'b0, 1'b1, 1'b0};
    exp[3] = {4'd0, 1'b1, 1'b0, 1'b1};
    exp[4] = {4'd0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    load = 1'b1; load_val = 4'd3;
    for (int i = 0; i < 6; i++) begin
      step();
      load = 1'b0; en = 1'b1; auto_reload = 1'b0;
      checks++;
      if ({q, tc, busy, done} !== exp[(i > 4) ? 4 : i]) begin
        errors++;
        $display("FAIL one_shot[%0d]: got {q,tc,busy,done}=%h, expected %h",
                 i, {q, tc, busy, done}, exp[(i > 4) ? 4 : i]);
      end
    end
  endtask

  task automatic test_periodic();
    logic [3:0] exp_q [9];
    logic       exp_tc [9];
    exp_q[0] = 4'd2; exp_q[1] = 4'd1; exp_q[2] = 4'd0;
    exp_q[3] = 4'd2; exp_q[4] = 4'd1; exp_q[5] = 4'd0;
    exp_q[6] = 4'd2; exp_q[7] = 4'd1; exp_q[8] = 4'd0;
    for (int i = 0; i < 9; i++) exp_tc[i] = (i % 3 == 2);
    idle_inputs();
    load = 1'b1; load_val = 4'd2; en = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      load = 1'b0;
      checks++;
      if ({q, tc, busy, done} !== {exp_q[i], exp_tc[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL periodic[%0d]: got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=1 done=0",
                 i, q, tc, busy, done, exp_q[i], exp_tc[i]);
      end
    end
  endtask

  task automatic test_enable_gating();
    logic       en_seq [4];
    logic [3:0] exp_q  [4];
    en_seq[0] = 1'b1; en_seq[1] = 1'b0; en_seq[2] = 1'b0; en_seq[3] = 1'b1;
    exp_q[0]  = 4'd4; exp_q[1]  = 4'd4; exp_q[2]  = 4'd4; exp_q[3]  = 4'd3;
    idle_inputs();
    load = 1'b1; load_val = 4'd5;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      step();
      checks++;
      if ({q, tc, busy, done} !== {exp_q[i], 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL enable_gating[%0d]: got q=%0d tc=%b busy=%b, expected q=%0d tc=0 busy=1",
                 i, q, tc, busy, exp_q[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    load = 1'b1; load_val = 4'd2;
    step();
    load = 1'b0; en = 1'b1;
    step();
    // q is now 1 in RUN; load must beat the terminal step
    load = 1'b1; load_val = 4'd7; en = 1'b1;
    step();
    checks++;
    if ({q, tc, busy, done} !== {4'd7, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_over_en: got q=%0d tc=%b busy=%b done=%b, expected q=7 tc=0 busy=1 done=0",
               q, tc, busy, done);
    end
    reset = 1'b1; load = 1'b1; load_val = 4'd9;
    step();
    idle_inputs();
    checks++;
    if ({q, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_over_load: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
               q, tc, busy, done);
    end
  endtask

  task automatic test_reset_abort();
    idle_inputs();
    load = 1'b1; load_val = 4'd1;
    step();
    load = 1'b0; en = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({q, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_abort: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
               q, tc, busy, done);
    end
    step();
    checks++;
    if ({q, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_abort_hold: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
               q, tc, busy, done);
    end
  endtask

  task automatic test_zero_load();
    idle_inputs();
    load = 1'b1; load_val = 4'd6;
    step();
    load_val = 4'd0;
    step();
    load = 1'b0;
    checks++;
    if ({q, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL zero_load: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
               q, tc, busy, done);
    end
    en = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({q, tc, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL zero_load_en[%0d]: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=0 busy=0 done=0",
                 i, q, tc, busy, done);
      end
    end
  endtask

  task automatic test_max_value();
    int cycles;
    int tc_count;
    idle_inputs();
    load = 1'b1; load_val = 4'd15;
    step();
    load = 1'b0; en = 1'b1;
    cycles = 0; tc_count = 0;
    while (q != 4'd0 && cycles < 40) begin
      step();
      cycles++;
      if (tc) tc_count++;
    end
    checks++;
    if (cycles !== 15) begin
      errors++;
      $display("FAIL max_cycles: got %0d enabled cycles to zero, expected 15", cycles);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (tc) tc_count++;
      checks++;
      if ({q, busy, done} !== {4'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL max_hold[%0d]: got q=%0d busy=%b done=%b, expected q=0 busy=0 done=1",
                 i, q, busy, done);
      end
    end
    checks++;
    if (tc_count !== 1) begin
      errors++;
      $display("FAIL max_tc_count: got %0d tc pulses, expected 1", tc_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [4];
    // Reload from DONE with 1 in periodic mode: period of two enabled cycles
    exp[0] = {4'd1, 1'b0, 1'b1, 1'b0};
    exp[1] = {4'd0, 1'b1, 1'b1, 1'b0};
    exp[2] = {4'd1, 1'b0, 1'b1, 1'b0};
    exp[3] = {4'd0, 1'b1, 1'b1, 1'b0};
    idle_inputs();
    load = 1'b1; load_val = 4'd1; en = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      load = 1'b0;
      checks++;
      if ({q, tc, busy, done} !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got {q,tc,busy,done}=%h, expected %h",
                 i, {q, tc, busy, done}, exp[i]);
      end
    end
    // Switch to one-shot while in RUN at q=0: reload happens, next terminal step ends in DONE
    auto_reload = 1'b0;
    step();
    step();
    checks++;
    if ({q, tc, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mode_switch: got q=%0d tc=%b busy=%b done=%b, expected q=0 tc=1 busy=0 done=1",
               q, tc, busy, done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_one_shot();
    test_periodic();
    test_enable_gating();
    test_simultaneous();
    test_reset_abort();
    test_zero_load();
    test_max_value();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
